// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, fetch FSM encoding and the canonical NOP word.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      ERR
   } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time and
// hands the fetched word to decode; loads npc on every retire.
module if_fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] npc,
   output logic [XLEN-1:0] pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   input  logic            inst_ready,
   output logic            fetch_misaligned
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic            misaligned_q, misaligned_d;
   logic            req_q, req_d;
   logic            valid_q, valid_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         misaligned_q <= 1'b0;
         req_q        <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         misaligned_q <= misaligned_d;
         req_q        <= req_d;
         valid_q      <= valid_d;
      end
   end

   // Next-state logic; handshake outputs are pre-decoded from the next state so they register cleanly.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      misaligned_d = misaligned_q;
      req_d        = 1'b0;
      valid_d      = 1'b0;

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_gnt) state_d = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               inst_d  = imem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (inst_ready) begin
               pc_d    = npc;
               state_d = (npc[1:0] == 2'b00) ? REQ : ERR;
            end
         end
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase

      misaligned_d = misaligned_q | (state_d == ERR);
      req_d        = (state_d == REQ);
      valid_d      = (state_d == HOLD);
   end

   assign pc               = pc_q;
   assign imem_addr        = pc_q;
   assign imem_req         = req_q;
   assign inst_valid       = valid_q;
   assign inst             = inst_q;
   assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed handshake scenarios plus a randomized memory/decode
// environment checked against a transaction-level PC/instruction model.
module tb_if_fetch;
   import cpu_pkg::*;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] npc;
   logic [31:0] pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic        inst_ready;
   logic        fetch_misaligned;

   int checks = 0;
   int errors = 0;

   if_fetch #(.RESET_PC(RST_PC)) dut (
      .clk              (clk),
      .rst              (rst),
      .npc              (npc),
      .pc               (pc),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_gnt         (imem_gnt),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .inst_valid       (inst_valid),
      .inst             (inst),
      .inst_ready       (inst_ready),
      .fetch_misaligned (fetch_misaligned)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Instruction memory contents as a pure function of address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0013;
   endfunction

   logic [31:0] model_pc;
   logic [31:0] pend_addr;
   logic        pending;
   int          delay;
   int          retires;
   int          stall;
   int          guard;

   initial begin
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      inst_ready = 1'b0; npc = '0;
      @(negedge clk); @(negedge clk);
      check("rst_pc", pc, RST_PC);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_inst", inst, 32'h0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_mis", 32'(fetch_misaligned), 32'd0);
      rst = 1'b0;

      // Back-to-back fetch: gnt immediately, rvalid next cycle, ready held.
      @(negedge clk);
      check("t1_req", 32'(imem_req), 32'd1);
      check("t1_addr", imem_addr, 32'h8000_0000);
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      check("t1_wait_req", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = NOP;
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("t1_valid", 32'(inst_valid), 32'd1);
      check("t1_inst", inst, NOP);
      inst_ready = 1'b1; npc = 32'h8000_0004;
      @(negedge clk);
      inst_ready = 1'b0;
      check("t1_next_req", 32'(imem_req), 32'd1);
      check("t1_next_addr", imem_addr, 32'h8000_0004);

      // Grant stalled 4 cycles, response delayed 3 cycles.
      for (int i = 0; i < 4; i++) begin
         check("t2_req_hold", 32'(imem_req), 32'd1);
         check("t2_addr_hold", imem_addr, 32'h8000_0004);
         @(negedge clk);
      end
      check("t2_req_gnt", 32'(imem_req), 32'd1);
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t2_wait_req", 32'(imem_req), 32'd0);
         check("t2_wait_valid", 32'(inst_valid), 32'd0);
         @(negedge clk);
      end
      imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
      @(negedge clk);
      imem_rvalid = 1'b0;

      // Decode back-pressure with a spurious response mid-hold.
      for (int i = 0; i < 5; i++) begin
         check("t3_valid", 32'(inst_valid), 32'd1);
         check("t3_inst", inst, 32'h1234_5678);
         check("t3_pc", pc, 32'h8000_0004);
         check("t3_req", 32'(imem_req), 32'd0);
         imem_rvalid = (i == 2);
         imem_rdata  = 32'hDEAD_BEEF;
         @(negedge clk);
      end
      imem_rvalid = 1'b0;
      check("t3_inst_after", inst, 32'h1234_5678);
      inst_ready = 1'b1; npc = 32'h8000_0100;
      @(negedge clk);
      inst_ready = 1'b0;
      check("t4_jump_pc", pc, 32'h8000_0100);
      check("t4_jump_addr", imem_addr, 32'h8000_0100);
      check("t4_jump_req", 32'(imem_req), 32'd1);

      // Randomized memory and decode timing against the transaction model.
      model_pc = 32'h8000_0100; pending = 1'b0; delay = 0;
      retires = 0; stall = 0; guard = 0;
      while (retires < 40 && guard < 4000) begin
         guard++;
         stall++;
         imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
         imem_rdata = $urandom; npc = $urandom;
         check("r_pc", pc, model_pc);
         if (imem_req) begin
            check("r_addr", imem_addr, model_pc);
            check("r_one_outstanding", 32'(pending), 32'd0);
            check("r_req_vs_valid", 32'(inst_valid), 32'd0);
            if ($urandom_range(2, 0) != 0) begin
               imem_gnt  = 1'b1;
               pending   = 1'b1;
               pend_addr = imem_addr;
               delay     = int'($urandom_range(3, 0));
            end
         end else if (pending) begin
            if (delay == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(pend_addr);
               pending     = 1'b0;
            end else begin
               delay--;
            end
         end else if ($urandom_range(3, 0) == 0) begin
            imem_rvalid = 1'b1;
         end
         if (inst_valid) begin
            check("r_inst", inst, mem_word(model_pc));
            check("r_mis", 32'(fetch_misaligned), 32'd0);
            if ($urandom_range(1, 0) == 1) begin
               inst_ready = 1'b1;
               npc = ($urandom_range(3, 0) == 0) ? ($urandom & 32'hFFFF_FFFC) : model_pc + 32'd4;
               model_pc = npc;
               retires++;
               stall = 0;
            end
         end
         if (stall > 60) begin
            check("r_watchdog", 32'(stall), 32'd0);
            guard = 4000;
         end
         @(negedge clk);
      end
      check("r_retires", 32'(retires), 32'd40);
      imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;

      // Misaligned npc: pc takes the faulting address and fetch stops.
      check("m_req", 32'(imem_req), 32'd1);
      check("m_addr", imem_addr, model_pc);
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = mem_word(model_pc);
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("m_valid", 32'(inst_valid), 32'd1);
      inst_ready = 1'b1; npc = 32'h8000_0102;
      @(negedge clk);
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("m_pc", pc, 32'h8000_0102);
         check("m_flag", 32'(fetch_misaligned), 32'd1);
         check("m_no_req", 32'(imem_req), 32'd0);
         check("m_no_valid", 32'(inst_valid), 32'd0);
         imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1; npc = 32'h8000_0200;
         @(negedge clk);
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;

      // Reset recovers from ERR, then reset again while waiting on memory.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("w_req", 32'(imem_req), 32'd1);
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      check("w_in_wait", 32'(imem_req), 32'd0);
      #1 rst = 1'b1;
      #1;
      check("w_async_pc", pc, RST_PC);
      check("w_async_valid", 32'(inst_valid), 32'd0);
      check("w_async_req", 32'(imem_req), 32'd0);
      check("w_async_mis", 32'(fetch_misaligned), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      imem_rvalid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("w_restart_req", 32'(imem_req), 32'd1);
      check("w_restart_addr", imem_addr, RST_PC);
      check("w_restart_inst", inst, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
